instr_mem_loader: RTL

//   Writer side of the byte-addressed, little-endian instruction memory.

---
 rtl/instr_mem_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Splits 32-bit instruction words into little-endian byte writes (1 accept + 4 write cycles per word).
// word_ready is high only while waiting for a word; the source holds word_valid until accepted.
module instr_mem_loader #(
  parameter int          ADDRESS_WIDTH = 16,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     word_valid,
  input  logic [DATA_WIDTH-1:0]    word_data,
  input  logic                     word_last,
  output logic                     word_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [7:0]               wr_byte,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDRESS_WIDTH-1:0] word_count
);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} stateT;

  // Address register carries one extra bit so that running past the top of
  // memory after an exact fit is seen as overflow instead of wrapping to 0.
  localparam logic [ADDRESS_WIDTH:0] baseAddrExt = BASE_ADDR[ADDRESS_WIDTH:0];

  stateT                  state, nextState;
  logic [ADDRESS_WIDTH:0] addrReg;
  logic [ADDRESS_WIDTH+1:0] endAddr;
  logic [1:0]             byteIdx, nextIdx;
  logic [DATA_WIDTH-1:0]  dataReg;
  logic                   lastReg;
  logic                   handshake, overflow;
  logic                   wordReadyNxt, wrEnNxt, busyNxt, doneNxt, errNxt;

  assign handshake = (state == ACCEPT) && word_valid && word_ready;
  assign endAddr   = {1'b0, addrReg} + (ADDRESS_WIDTH+2)'(3);
  assign overflow  = endAddr[ADDRESS_WIDTH+1:ADDRESS_WIDTH] != 2'b00;
  assign nextIdx   = byteIdx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= nextState;
      word_ready <= wordReadyNxt;
      wr_en      <= wrEnNxt;
      busy       <= busyNxt;
      done       <= doneNxt;
      err        <= errNxt;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, ERROR: if (start) nextState = ACCEPT;
      ACCEPT:            if (handshake) nextState = overflow ? ERROR : WRITE;
      WRITE:             if (byteIdx == 2'd3) nextState = lastReg ? DONE : ACCEPT;
      default:           nextState = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    wordReadyNxt = (nextState == ACCEPT);
    wrEnNxt      = (nextState == WRITE);
    busyNxt      = (nextState == ACCEPT) || (nextState == WRITE);
    doneNxt      = (nextState == DONE);
    errNxt       = (nextState == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrReg    <= baseAddrExt;
      byteIdx    <= 2'd0;
      dataReg    <= '0;
      lastReg    <= 1'b0;
      wr_addr    <= baseAddrExt[ADDRESS_WIDTH-1:0];
      wr_byte    <= 8'h00;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            addrReg    <= baseAddrExt;
            word_count <= '0;
          end
        end
        ACCEPT: begin
          if (handshake) begin
            dataReg <= word_data;
            lastReg <= word_last;
            byteIdx <= 2'd0;
            if (!overflow) begin
              wr_addr <= addrReg[ADDRESS_WIDTH-1:0];
              wr_byte <= word_data[7:0];
            end
          end
        end
        WRITE: begin
          if (byteIdx == 2'd3) begin
            addrReg    <= addrReg + (ADDRESS_WIDTH+1)'(4);
            word_count <= word_count + ADDRESS_WIDTH'(1);
          end else begin
            byteIdx <= nextIdx;
            wr_addr <= wr_addr + ADDRESS_WIDTH'(1);
            wr_byte <= dataReg[{nextIdx, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
